// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - SHA-256 round constants, IV, FSM state type and bit-mixing functions
package sha256_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FINAL = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Word 7 is a / H0 so the packed vector matches {H0..H7} bus packing.
    typedef logic [7:0][31:0] hash_t;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                       input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/sha256_core_if.sv
// rtl/sha256_core_if.sv - start/result handshake bundle for sha256_core
interface sha256_core_if;
    logic         start;
    logic [255:0] start_state;
    logic [511:0] input_message;
    logic         done;
    logic [255:0] result;

    modport master (
        output start, start_state, input_message,
        input  done, result
    );

    modport slave (
        input  start, start_state, input_message,
        output done, result
    );
endinterface

// File: rtl/sha256_round.sv
// rtl/sha256_round.sv - one combinational SHA-256 compression round
module sha256_round
    import sha256_pkg::*;
(
    input  hash_t       cur,
    input  logic [31:0] k,
    input  logic [31:0] w,
    output hash_t       nxt
);
    logic [31:0] t1;
    logic [31:0] t2;

    // cur[7..0] = a,b,c,d,e,f,g,h
    always_comb begin
        t1  = cur[0] + big_sigma1(cur[3]) + ch(cur[3], cur[2], cur[1]) + k + w;
        t2  = big_sigma0(cur[7]) + maj(cur[7], cur[6], cur[5]);
        nxt = {t1 + t2, cur[7], cur[6], cur[5], cur[4] + t1, cur[3], cur[2], cur[1]};
    end
endmodule

// File: rtl/sha256_core.sv
// rtl/sha256_core.sv - single-block SHA-256 compression, one round per clock; SHA256_DONE_PULSE_EN makes done a pulse
module sha256_core
    import sha256_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    sha256_core_if.slave   bus
);
    state_t      state;
    hash_t       h_reg;
    hash_t       work;
    hash_t       work_nxt;
    hash_t       sum;
    logic [31:0] win [16];
    logic [31:0] w_new;
    logic [5:0]  round;

    sha256_round u_round (
        .cur (work),
        .k   (K[round]),
        .w   (win[0]),
        .nxt (work_nxt)
    );

    // win[0] is W[t]; the word entering the window is W[t+16].
    assign w_new = small_sigma1(win[14]) + win[9] + small_sigma0(win[1]) + win[0];

    always_comb begin
        sum = '0;
        for (int i = 0; i < 8; i++) begin
            sum[i] = h_reg[i] + work[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            h_reg      <= '0;
            work       <= '0;
            round      <= '0;
            bus.done   <= 1'b0;
            bus.result <= '0;
            for (int i = 0; i < 16; i++) begin
                win[i] <= '0;
            end
        end else if ((state == ST_IDLE || state == ST_DONE) && bus.start) begin
            h_reg    <= bus.start_state;
            work     <= bus.start_state;
            round    <= '0;
            bus.done <= 1'b0;
            state    <= ST_RUN;
            for (int i = 0; i < 16; i++) begin
                win[i] <= bus.input_message[511 - 32*i -: 32];
            end
        end else begin
            case (state)
                ST_IDLE: bus.done <= 1'b0;
                ST_RUN: begin
                    work  <= work_nxt;
                    round <= round + 6'd1;
                    for (int i = 0; i < 15; i++) begin
                        win[i] <= win[i + 1];
                    end
                    win[15] <= w_new;
                    if (round == 6'd63) begin
                        state <= ST_FINAL;
                    end
                end
                ST_FINAL: begin
                    bus.result <= sum;
                    bus.done   <= 1'b1;
`ifdef SHA256_DONE_PULSE_EN
                    state      <= ST_IDLE;
`else
                    state      <= ST_DONE;
`endif
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sha256_core.sv
// tb/tb_sha256_core.sv - randomized and known-answer bench for sha256_core
module tb_sha256_core;
    import sha256_pkg::*;

    logic clk = 1'b0;
    logic rst;
    sha256_core_if bus ();

    sha256_core dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [255:0] st;
    logic [255:0] res;
    logic [255:0] expd;
    logic [511:0] msg;
    int           lat;
    int           done_times[$];
    int           exp_times [3] = '{65, 131, 197};
    string        s55 = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] ref_compress(input logic [255:0] s, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] s0, s1, t1, t2;
        logic [255:0] out;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = s1 + w[t-7] + s0 + w[t-16];
        end
        for (int i = 0; i < 8; i++) v[i] = s[255 - 32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[t] + w[t];
            t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) out[255 - 32*i -: 32] = s[255 - 32*i -: 32] + v[i];
        return out;
    endfunction

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [255:0] s, input logic [511:0] m,
                          output logic [255:0] r, output int l);
        bus.start         = 1'b1;
        bus.start_state   = s;
        bus.input_message = m;
        tick();
        bus.start = 1'b0;
        l = 0;
        do begin
            tick();
            l++;
        end while (bus.done !== 1'b1 && l < 200);
        r = bus.result;
    endtask

    task automatic rand_inputs();
        for (int i = 0; i < 8; i++) st[32*i +: 32] = $urandom();
        for (int i = 0; i < 16; i++) msg[32*i +: 32] = $urandom();
    endtask

    initial begin
        rst               = 1'b0;
        bus.start         = 1'b0;
        bus.start_state   = '0;
        bus.input_message = '0;
        tick();
        tick();
        check("reset_done", bus.done, 1'b0);
        check("reset_result", bus.result, '0);
        rst = 1'b1;

        msg = {1'b1, 511'b0};
        run_op(IV, msg, res, lat);
        check("empty_digest", res,
              256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855);
        check("empty_latency", lat, 65);
        tick();
`ifdef SHA256_DONE_PULSE_EN
        check("done_after", bus.done, 1'b0);
`else
        check("done_after", bus.done, 1'b1);
`endif
        check("result_held", bus.result, res);

        msg = {24'h616263, 8'h80, 416'b0, 64'h18};
        run_op(IV, msg, res, lat);
        check("abc_digest", res,
              256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad);
        check("abc_latency", lat, 65);

        msg = '0;
        for (int i = 0; i < 55; i++) msg[511 - 8*i -: 8] = s55[i];
        msg[511 - 8*55 -: 8] = 8'h80;
        msg[63:0] = 64'h1b8;
        run_op(IV, msg, res, lat);
        check("str55_digest", res, ref_compress(IV, msg));

        for (int r = 0; r < 6; r++) begin
            rand_inputs();
            run_op(st, msg, res, lat);
            check("rand_digest", res, ref_compress(st, msg));
            check("rand_latency", lat, 65);
        end

        // inputs scrambled after acceptance plus a stray start mid-run
        rand_inputs();
        expd = ref_compress(st, msg);
        bus.start         = 1'b1;
        bus.start_state   = st;
        bus.input_message = msg;
        tick();
        bus.start         = 1'b0;
        bus.input_message = ~msg;
        bus.start_state   = ~st;
        lat = 0;
        while (lat < 20) begin
            tick();
            lat++;
        end
        bus.start = 1'b1;
        tick();
        lat++;
        bus.start = 1'b0;
        while (bus.done !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
        check("latch_digest", bus.result, expd);
        check("latch_latency", lat, 65);

        // reset during round 30
        rand_inputs();
        bus.start         = 1'b1;
        bus.start_state   = st;
        bus.input_message = msg;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        rst = 1'b0;
        tick();
        check("midrst_done", bus.done, 1'b0);
        check("midrst_result", bus.result, '0);
        rst = 1'b1;
        tick();
        check("midrst_idle_done", bus.done, 1'b0);
        rand_inputs();
        run_op(st, msg, res, lat);
        check("post_rst_digest", res, ref_compress(st, msg));

        // start held high: identical results every 66 cycles
        msg  = {24'h616263, 8'h80, 416'b0, 64'h18};
        expd = ref_compress(IV, msg);
        bus.start         = 1'b1;
        bus.start_state   = IV;
        bus.input_message = msg;
        tick();
        for (int c = 1; c <= 200; c++) begin
            tick();
            if (bus.done === 1'b1) begin
                done_times.push_back(c);
                check("hold_digest", bus.result, expd);
            end
        end
        bus.start = 1'b0;
        check("hold_count", done_times.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check("hold_time", (i < done_times.size()) ? done_times[i] : -1, exp_times[i]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sha256_core.md
# sha256_core

Single-block SHA-256 compression engine, FIPS 180-4. On a start request it takes one pre-padded 512-bit message block and a 256-bit chaining state, runs 64 rounds at one round per clock, and returns the updated 256-bit hash. It is the hashing datapath under the mining/hash controller. Padding, multi-block chaining and length handling belong to the caller.

## Interface
- No parameters.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-low reset (`rst`=0 resets on the next rising edge).
- `start` in 1: request to begin compression; sampled only in IDLE or DONE.
- `start_state` in 256: chaining input H0..H7, with H0 at [255:224] and H7 at [31:0].
- `input_message` in 512: block words W0..W15, with W0 at [511:480] and W15 at [31:0].
- `done` out 1: result valid.
- `result` out 256: H0'..H7', same packing as `start_state`.

## Operation
- States:
  - IDLE: reset state.
  - RUN: rounds 0..63.
  - FINAL: feed-forward add.
  - DONE: result presented.
- IDLE or DONE with `start`=1:
  - Latch `start_state` into H[0..7] and into working registers a..h.
  - Latch `input_message` into the 16-word schedule window.
  - Clear the round counter and go to RUN.
- RUN, one round per cycle t:
  - T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + W[t]
  - T2 = Σ0(a) + Maj(a,b,c)
  - h=g, g=f, f=e, e=d+T1, d=c, c=b, b=a, a=T1+T2.
  - For t≥16: W[t] = σ1(W[t-2]) + W[t-7] + σ0(W[t-15]) + W[t-16]; the window shifts by one word per round.
  - All arithmetic is mod 2^32 and carries are discarded.
  - After t=63, go to FINAL.
- FINAL: `result` = {H0+a, …, H7+h}, each a 32-bit mod add; go to DONE.
- DONE: `done`=1 and `result` is held stable until the next accepted `start`.
- Because inputs are latched, `start_state` and `input_message` may change after the accepting edge.
- `start` during RUN or FINAL is ignored; there is no abort and no queueing.
- `start` held high in DONE re-launches on each acceptance; the same inputs give the same result.

## Timing
- Start is accepted at edge N.
- Rounds 0..63 complete at edges N+1..N+64.
- FINAL add completes at edge N+65; `done` rises and `result` is valid from that edge.
- Latency is 65 cycles from the accepting edge to `done`.
- `done` falls on the edge that accepts a new `start`.
- Reset values:
  - `done`=0 and `result`=0.
  - Working registers, H registers and the round counter are 0.
  - State is IDLE.
- Reset asserted mid-operation aborts the operation; IDLE is reached on that edge and no `done` is produced.

## Configuration
- Macro `SHA256_DONE_PULSE_EN`, undefined by default.
- Defined: `done` is a one-cycle pulse at edge N+65, then the FSM returns to IDLE; `result` still holds until the next start.
- Undefined: `done` is a level, as described above.

## Structure
- Package `sha256_pkg` holds:
  - the 64-entry K round-constant array and the FIPS IV constants (for benches);
  - the FSM state enum;
  - the functions Σ0, Σ1, σ0, σ1, Ch and Maj.
- One sub-module, `sha256_round`, is combinational: inputs a..h, K[t] and W[t]; outputs the next a..h.
- The core instantiates `sha256_round` once and owns the FSM, the counter, the schedule window and the feed-forward adders.

## Test plan
- Empty message (`input_message` = {1'b1, 511'b0}), IV `start_state`:
  - `result` = e3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855.
  - `done` exactly 65 cycles after start.
- "abc" (616263_80_0…0_18), IV:
  - `result` = ba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad.
- 55-byte "abcdbcde…mnop" padded to one block (length 0x1b8), IV:
  - `result` equals a software SHA-256 model output.
  - Repeat with random blocks and random `start_state` against the model's compression function.
- Change `input_message` one cycle after start, and pulse `start` again mid-RUN:
  - `result` is unaffected.
  - `done` still lands at N+65.
- Assert `rst`=0 during round 30:
  - Next cycle `done`=0 and `result`=0.
  - A new start yields the correct digest.
- Hold `start`=1 continuously:
  - Back-to-back identical results every 66 cycles.
  - With `SHA256_DONE_PULSE_EN`, `done` is high for exactly one cycle per operation.
